// File: rtl/vsched_if.sv
// vsched_if -- handshake bundle between the vertical-blank update scheduler and
// its environment (vertical timing, four update units, status consumer).
//
// Signals:
//   vreset    frame-start pulse from vertical timing
//   vblank    vertical blanking level; updates only allowed while high
//   en_mask   per-unit enable, bit i = 0 skips unit i
//   done      per-unit completion acknowledge
//   clr       pulse clearing the sticky error flags
//   go        one-hot update strobe to unit i
//   busy      sequence in progress
//   seq_done  pulse on sequence completion
//   frame_cnt count of completed sequences (FRAME_W bits)
//   overrun   sticky: aborted sequence or vreset while busy
//   wdog_err  sticky: unit watchdog timeout
//
// Modports: master = scheduler side, slave = environment side.
interface vsched_if #(
    parameter int unsigned FRAME_W = 8
) ();
    logic               vreset;
    logic               vblank;
    logic [3:0]         en_mask;
    logic [3:0]         done;
    logic               clr;
    logic [3:0]         go;
    logic               busy;
    logic               seq_done;
    logic [FRAME_W-1:0] frame_cnt;
    logic               overrun;
    logic               wdog_err;

    modport master (
        input  vreset, vblank, en_mask, done, clr,
        output go, busy, seq_done, frame_cnt, overrun, wdog_err
    );

    modport slave (
        output vreset, vblank, en_mask, done, clr,
        input  go, busy, seq_done, frame_cnt, overrun, wdog_err
    );
endinterface

// File: rtl/vsched.sv
// vsched -- sequences one-shot update strobes to four units during vertical
// blanking. A vreset pulse in idle walks units 0..3 in order; each enabled unit
// gets a one-cycle go strobe and is then waited on until it acknowledges with
// done. Disabled units cost one cycle each. Dropping vblank mid-sequence
// aborts it and flags overrun.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high reset
//   bus    vsched_if.master (vreset, vblank, en_mask, done, clr in;
//          go, busy, seq_done, frame_cnt, overrun, wdog_err out)
//
// Parameters:
//   TIMEOUT  watchdog limit in clk cycles per unit wait (2..255)
//   FRAME_W  frame counter width
//
// Build option: define VSCHED_WDOG_EN to include the per-unit watchdog. Without
// it, WAIT only exits on done or abort and wdog_err is tied to 0.
module vsched #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned FRAME_W = 8
) (
    input logic      clk,
    input logic      reset,
    vsched_if.master bus
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("vsched: TIMEOUT must be within 2..255");
    end

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StNext,
        StDone
    } state_e;

    state_e             state_q;
    logic [1:0]         idx_q;
    logic [3:0]         go_q;
    logic               busy_q;
    logic               seq_done_q;
    logic [FRAME_W-1:0] frame_q;
    logic               overrun_q;

    logic [1:0]         idx_inc;
    logic               in_seq;
    logic               abort;

    assign idx_inc = idx_q + 2'd1;
    // Only the walking states can be aborted; DONE always completes.
    assign in_seq  = (state_q == StIssue) || (state_q == StWait) || (state_q == StNext);
    assign abort   = in_seq && !bus.vblank;

`ifdef VSCHED_WDOG_EN
    logic [7:0] wdog_cnt_q;
    logic       wdog_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            go_q       <= 4'b0000;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            frame_q    <= '0;
            overrun_q  <= 1'b0;
`ifdef VSCHED_WDOG_EN
            wdog_cnt_q <= 8'd0;
            wdog_err_q <= 1'b0;
`endif
        end else begin
            go_q       <= 4'b0000;
            seq_done_q <= 1'b0;

            // Clear first; any set below overrides it in the same cycle.
            if (bus.clr) begin
                overrun_q <= 1'b0;
`ifdef VSCHED_WDOG_EN
                wdog_err_q <= 1'b0;
`endif
            end
            if (bus.vreset && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end

            if (abort) begin
                state_q   <= StIdle;
                busy_q    <= 1'b0;
                overrun_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.vreset) begin
                            idx_q  <= 2'd0;
                            busy_q <= 1'b1;
                            if (bus.en_mask[0]) begin
                                state_q <= StIssue;
                                go_q    <= 4'b0001;
                            end else begin
                                state_q <= StNext;
                            end
                        end
                    end
                    StIssue: begin
                        state_q <= StWait;
`ifdef VSCHED_WDOG_EN
                        wdog_cnt_q <= 8'd0;
`endif
                    end
                    StWait: begin
                        if (bus.done[idx_q]) begin
                            state_q <= StNext;
`ifdef VSCHED_WDOG_EN
                        end else if (wdog_cnt_q == 8'(TIMEOUT - 1)) begin
                            // TIMEOUT wait cycles elapsed with no acknowledge.
                            state_q    <= StNext;
                            wdog_err_q <= 1'b1;
                        end else begin
                            wdog_cnt_q <= wdog_cnt_q + 8'd1;
`endif
                        end
                    end
                    StNext: begin
                        if (idx_q == 2'd3) begin
                            state_q    <= StDone;
                            seq_done_q <= 1'b1;
                            frame_q    <= frame_q + FRAME_W'(1);
                        end else begin
                            idx_q <= idx_inc;
                            if (bus.en_mask[idx_inc]) begin
                                state_q <= StIssue;
                                go_q    <= 4'b0001 << idx_inc;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.go        = go_q;
    assign bus.busy      = busy_q;
    assign bus.seq_done  = seq_done_q;
    assign bus.frame_cnt = frame_q;
    assign bus.overrun   = overrun_q;
`ifdef VSCHED_WDOG_EN
    assign bus.wdog_err  = wdog_err_q;
`else
    assign bus.wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_vsched.sv
// tb_vsched -- randomized self-checking bench for vsched. Each sequence is
// planned up front: the sample at which every go pulse, done acknowledge,
// seq_done and sticky-flag change must appear is computed from the unit
// timing rules (issue, wait latency, one cycle per skipped unit), then the
// plan is driven and every output is compared on each sample.
module tb_vsched;
    localparam int unsigned TO   = 64;
    localparam int          MAXS = 420;
    localparam int          TAIL = 2;

    logic clk = 1'b0;
    logic reset;

    vsched_if #(.FRAME_W(8)) bus ();

    vsched #(
        .TIMEOUT(TO),
        .FRAME_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference state carried between sequences.
    int exp_frame;
    bit exp_ov;
    bit exp_wd;

    // Per-sample plan, indexed by samples after the vreset edge.
    logic [3:0] go_e   [MAXS];
    logic [3:0] done_d [MAXS];
    logic [3:0] em_d   [MAXS];
    bit         vr_d   [MAXS];
    bit         clr_d  [MAXS];
    bit         vb_d   [MAXS];
    bit         ovset  [MAXS];
    bit         wdset  [MAXS];

    function automatic int pick_lat();
        int r = $urandom_range(0, 15);
`ifdef VSCHED_WDOG_EN
        if (r == 0) return TO;        // done lands on the timeout cycle
        if (r == 1) return TO + 10;   // unit never answers in time
`else
        if (r == 0) return 70;
`endif
        return $urandom_range(1, 4);
    endfunction

    // mask_sel < 0: random masks with a mid-sequence change; lat_sel 0: random
    // latency; mute: unit that never answers (-1 none).
    task automatic run_seq(input int mask_sel, input int lat_sel, input int mute,
                           input bit abort_en);
        logic [3:0] m0, m1, en_use;
        int p, q, lat, eff, chg, dsamp, last, k, base;
        bit aborted, directed;

        directed = (mask_sel >= 0);
        if (directed) begin
            m0  = mask_sel[3:0];
            m1  = m0;
            chg = MAXS;
        end else begin
            m0  = 4'($urandom);
            m1  = 4'($urandom);
            chg = $urandom_range(0, 60);
        end

        for (int s = 0; s < MAXS; s++) begin
            go_e[s]   = 4'b0000;
            done_d[s] = 4'($urandom);
            em_d[s]   = (s >= chg) ? m1 : m0;
            vr_d[s]   = 1'b0;
            clr_d[s]  = directed ? 1'b0 : ($urandom_range(0, 15) == 0);
            vb_d[s]   = 1'b1;
            ovset[s]  = 1'b0;
            wdset[s]  = 1'b0;
        end

        // Unit i is reached at sample p; an enabled unit issues there, waits,
        // and its NEXT sample follows the acknowledge; a skipped unit is NEXT at p.
        p = 0;
        for (int i = 0; i < 4; i++) begin
            en_use = (p >= chg + 1) ? m1 : m0;
            if (en_use[i]) begin
                go_e[p] = 4'b0001 << i;
                if (i == mute) lat = TO + 10;
                else if (lat_sel > 0) lat = lat_sel;
                else lat = pick_lat();
`ifdef VSCHED_WDOG_EN
                eff = (lat > int'(TO)) ? int'(TO) : lat;
`else
                eff = lat;
`endif
                for (int w = 1; w < eff; w++) done_d[p + w][i] = 1'b0;
                if (eff == lat) begin
                    done_d[p + lat][i] = 1'b1;
                end else begin
                    done_d[p + eff][i] = 1'b0;
                    wdset[p + eff]     = 1'b1;
                end
                q = p + eff + 1;
            end else begin
                q = p;
            end
            p = q + 1;
        end
        dsamp = p;

        aborted = abort_en;
        k       = 0;
        if (aborted) begin
            k        = $urandom_range(0, dsamp - 1);
            vb_d[k]  = 1'b0;
            ovset[k] = 1'b1;
        end
        last = aborted ? k : dsamp;

        if (!directed && last >= 1 && $urandom_range(0, 2) == 0) begin
            int s = $urandom_range(1, last);
            vr_d[s]  = 1'b1;
            ovset[s] = 1'b1;
            if ($urandom_range(0, 1) == 1) clr_d[s] = 1'b1;
        end

        base        = exp_frame;
        bus.en_mask = m0;
        bus.vblank  = 1'b1;
        bus.vreset  = 1'b1;
        for (int s = 0; s <= last + TAIL; s++) begin
            bit completed;
            @(posedge clk);
            #1;
            completed = !aborted && s >= dsamp;
            check($sformatf("go s%0d", s), 32'(bus.go), 32'((s <= last) ? go_e[s] : 4'b0000));
            check($sformatf("busy s%0d", s), 32'(bus.busy), 32'(s <= last));
            check($sformatf("seq_done s%0d", s), 32'(bus.seq_done),
                  32'(!aborted && s == dsamp));
            check($sformatf("frame_cnt s%0d", s), 32'(bus.frame_cnt),
                  32'((base + (completed ? 1 : 0)) % 256));
            check($sformatf("overrun s%0d", s), 32'(bus.overrun), 32'(exp_ov));
            check($sformatf("wdog_err s%0d", s), 32'(bus.wdog_err), 32'(exp_wd));

            bus.vreset  = vr_d[s];
            bus.en_mask = em_d[s];
            bus.done    = done_d[s];
            bus.vblank  = vb_d[s];
            bus.clr     = clr_d[s];

            if (ovset[s]) exp_ov = 1'b1;
            else if (clr_d[s]) exp_ov = 1'b0;
            if (wdset[s] && (!aborted || s < k)) exp_wd = 1'b1;
            else if (clr_d[s]) exp_wd = 1'b0;
        end
        if (!aborted) exp_frame = (exp_frame + 1) % 256;
    endtask

    task automatic reset_mid_wait();
        bus.en_mask = 4'hF;
        bus.vblank  = 1'b1;
        bus.vreset  = 1'b1;
        bus.done    = 4'h0;
        bus.clr     = 1'b0;
        @(posedge clk);
        #1;
        check("rst go0", 32'(bus.go), 32'h1);
        bus.vreset = 1'b0;
        @(posedge clk);
        #1;
        check("rst busy wait", 32'(bus.busy), 32'h1);
        // Reset must beat vreset-while-busy and done in the same cycle.
        reset      = 1'b1;
        bus.vreset = 1'b1;
        bus.done   = 4'hF;
        @(posedge clk);
        #1;
        check("rst go", 32'(bus.go), 32'h0);
        check("rst busy", 32'(bus.busy), 32'h0);
        check("rst seq_done", 32'(bus.seq_done), 32'h0);
        check("rst frame_cnt", 32'(bus.frame_cnt), 32'h0);
        check("rst overrun", 32'(bus.overrun), 32'h0);
        check("rst wdog_err", 32'(bus.wdog_err), 32'h0);
        reset      = 1'b0;
        bus.vreset = 1'b0;
        bus.done   = 4'h0;
        exp_frame  = 0;
        exp_ov     = 1'b0;
        exp_wd     = 1'b0;
        @(posedge clk);
        #1;
        check("rst idle after", 32'(bus.busy), 32'h0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.vreset  = 1'b0;
        bus.vblank  = 1'b1;
        bus.en_mask = 4'h0;
        bus.done    = 4'h0;
        bus.clr     = 1'b0;
        exp_frame   = 0;
        exp_ov      = 1'b0;
        exp_wd      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init go", 32'(bus.go), 32'h0);
        check("init busy", 32'(bus.busy), 32'h0);
        check("init seq_done", 32'(bus.seq_done), 32'h0);
        check("init frame_cnt", 32'(bus.frame_cnt), 32'h0);
        check("init overrun", 32'(bus.overrun), 32'h0);
        check("init wdog_err", 32'(bus.wdog_err), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_seq(4'b1111, 3, -1, 1'b0);
        run_seq(4'b0101, 1, -1, 1'b0);
        run_seq(4'b0000, 0, -1, 1'b0);
`ifdef VSCHED_WDOG_EN
        run_seq(4'b1111, 1, 1, 1'b0);
`endif
        for (int n = 0; n < 320; n++) begin
            run_seq(-1, 0, -1, $urandom_range(0, 5) == 0);
        end
        reset_mid_wait();
        run_seq(4'b1111, 2, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vsched.md
VSCHED -- requirements
Module: vsched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, the watchdog limit in clk cycles per unit wait (legal range 2..255).
REQ-002 SHALL have parameter FRAME_W, default 8, the width of the frame counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port vreset, input, 1 bit: one-cycle frame-start pulse from vertical timing.
REQ-006 SHALL have port vblank, input, 1 bit: vertical blanking level; updates are permitted only while it is high.
REQ-007 SHALL have port en_mask, input, 4 bits: per-unit enable; bit i=0 means unit i is skipped.
REQ-008 SHALL have port done, input, 4 bits: done[i] is unit i's completion acknowledge.
REQ-009 SHALL have port clr, input, 1 bit: one-cycle pulse that clears the sticky error flags.
REQ-010 SHALL have port go, output, 4 bits: one-hot, one-cycle, registered update strobe to unit i.
REQ-011 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-012 SHALL have port seq_done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-013 SHALL have port frame_cnt, output, FRAME_W bits: count of completed sequences.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag for an aborted sequence or a vreset received while busy.
REQ-015 SHALL have port wdog_err, output, 1 bit: sticky flag for a unit watchdog timeout.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, NEXT and DONE, with a 2-bit unit index idx.
REQ-017 In IDLE, vreset=1 SHALL set idx=0 and move to NEXT if en_mask[0]=0, otherwise to ISSUE.
REQ-018 vreset asserted in IDLE at edge t SHALL make go[0]=1 during cycle t+1 when unit 0 is enabled.
REQ-019 ISSUE SHALL assert go[idx] for exactly one cycle, then move to WAIT.
REQ-020 WAIT SHALL sample done[idx] and move to NEXT when it is 1; all other done bits SHALL be ignored.
REQ-021 done[idx] high in the ISSUE cycle SHALL be ignored; an acknowledge counts only in WAIT.
REQ-022 NEXT SHALL move to DONE if idx=3; otherwise it SHALL set idx=idx+1 and go to ISSUE if that unit is enabled, or stay in NEXT if it is not.
REQ-023 Each skipped unit SHALL cost one cycle; en_mask=0000 SHALL give vreset -> seq_done in 5 cycles with no go pulse.
REQ-024 DONE SHALL pulse seq_done for one cycle, increment frame_cnt modulo 2^FRAME_W (wrapping from all-ones to 0), and return to IDLE.
REQ-025 busy SHALL be 1 in ISSUE, WAIT, NEXT and DONE, and 0 in IDLE.
REQ-026 vblank=0 in ISSUE, WAIT or NEXT SHALL abort to IDLE on the next edge: go forced to 0, overrun set, frame_cnt unchanged, no seq_done.
REQ-027 If done[idx] and vblank=0 coincide in WAIT, the abort SHALL take priority.
REQ-028 vreset while busy SHALL be ignored for sequencing and SHALL set overrun.
REQ-029 en_mask SHALL be sampled at each IDLE/NEXT decision; a change mid-sequence affects only units not yet reached.
REQ-030 clr SHALL clear overrun and wdog_err; if clr and a set event occur in the same cycle, set SHALL win.

Reset
REQ-031 reset=1 SHALL force, on the next edge and from any state: state=IDLE, idx=0, go=0000, busy=0, seq_done=0, frame_cnt=0, overrun=0, wdog_err=0, watchdog count=0.
REQ-032 reset SHALL take priority over vreset, done and clr in the same cycle.

Configuration
REQ-033 Macro VSCHED_WDOG_EN SHALL control the watchdog: when defined, a counter clears on entry to WAIT and increments each WAIT cycle.
REQ-034 With VSCHED_WDOG_EN defined, TIMEOUT WAIT cycles without done[idx] SHALL set wdog_err and move to NEXT, skipping the unit; done arriving on the timeout cycle wins and does not set wdog_err.
REQ-035 With VSCHED_WDOG_EN undefined, no watchdog logic SHALL exist, WAIT SHALL wait indefinitely (exit only on done or vblank abort), and wdog_err SHALL be constant 0.

Verification
REQ-036 Case 1: en_mask=1111, vblank=1, each unit answers done 3 cycles after its go, vreset pulse -> go sequence 0001, 0010, 0100, 1000, one seq_done, frame_cnt 0->1, overrun=0.
REQ-037 Case 2: en_mask=0101, immediate done -> go pulses only on units 0 and 2, NEXT costs one cycle per skipped unit, seq_done asserted.
REQ-038 Case 3: unit 1 never answers, VSCHED_WDOG_EN defined, TIMEOUT=64 -> wdog_err set 64 cycles after WAIT entry, then go[2] issued; clr then clears it.
REQ-039 Case 4: vblank dropped while in WAIT on unit 2 -> next cycle busy=0, overrun=1, no seq_done, frame_cnt unchanged.
REQ-040 Case 5: 256 complete sequences with FRAME_W=8 -> frame_cnt wraps from 255 to 0; vreset while busy -> overrun=1 and the sequence is unaffected.
REQ-041 Case 6: reset asserted mid-WAIT -> all outputs at their reset values next cycle; the following vreset starts a fresh sequence at unit 0.
